// File: rtl/register_bank.sv
// ---------------------------------------------------------------------------
// register_bank
//   A bank of N = 2*PAIRS byte registers, also addressable as 16-bit-style
//   pairs {reg[2p], reg[2p+1]} (even index = high byte).
//   - Two combinational byte read ports plus one pair read port.
//   - One byte write, one pair write and one pair increment/decrement per
//     cycle. When several of them hit the same byte, the byte write wins,
//     then the pair write, then the step.
//   - The flag register only stores the bits set in FLAG_MASK.
//   - An out-of-range address reads as zero. A write or step to such an
//     address does nothing.
//
// Ports
//   i_Clk          system clock, rising edge
//   i_Reset_n      asynchronous active-low reset
//   i_Enable       update gate; when 0 every register holds
//   i_RdAddrA/B    byte read addresses       -> o_RdDataA/B
//   i_RdPair       pair read address         -> o_RdPairData
//   i_WrByte       byte write strobe, with i_WrAddr / i_WrData
//   i_WrPair       pair write strobe, with i_WrPairAddr / i_WrPairData
//   i_IncDec       pair step: 01 increment, 10 decrement, 00/11 no-op
//   i_IncDecPair   pair targeted by the step
// ---------------------------------------------------------------------------
module register_bank #(
    parameter int               WIDTH     = 8,
    parameter int               PAIRS     = 4,
    parameter logic [WIDTH-1:0] INITIAL   = '0,
    parameter int               FLAG_REG  = 7,
    parameter logic [WIDTH-1:0] FLAG_MASK = 8'hF0,
    localparam int              N         = 2 * PAIRS,
    localparam int              AW        = (N > 2) ? $clog2(N) : 1,
    localparam int              PW        = (PAIRS > 2) ? $clog2(PAIRS) : 1
) (
    input  logic                 i_Clk,
    input  logic                 i_Reset_n,
    input  logic                 i_Enable,
    input  logic [AW-1:0]        i_RdAddrA,
    input  logic [AW-1:0]        i_RdAddrB,
    output logic [WIDTH-1:0]     o_RdDataA,
    output logic [WIDTH-1:0]     o_RdDataB,
    input  logic [PW-1:0]        i_RdPair,
    output logic [2*WIDTH-1:0]   o_RdPairData,
    input  logic                 i_WrByte,
    input  logic [AW-1:0]        i_WrAddr,
    input  logic [WIDTH-1:0]     i_WrData,
    input  logic                 i_WrPair,
    input  logic [PW-1:0]        i_WrPairAddr,
    input  logic [2*WIDTH-1:0]   i_WrPairData,
    input  logic [1:0]           i_IncDec,
    input  logic [PW-1:0]        i_IncDecPair
);

    localparam logic [2*WIDTH-1:0] ONE = 1;

    logic [N-1:0][WIDTH-1:0]           w_regs;
    logic [PAIRS-1:0]                  w_pair_hit;
    logic [PAIRS-1:0]                  w_step_hit;
    logic [PAIRS-1:0][2*WIDTH-1:0]     w_step_val;

    // Read tables are padded to the full address space so any address
    // decodes directly; the padding entries are constant zero.
    logic [(1<<AW)-1:0][WIDTH-1:0]     w_rd_bytes;
    logic [(1<<PW)-1:0][2*WIDTH-1:0]   w_rd_pairs;

    genvar gi;

    // Per-pair decode and step arithmetic. The step is computed on the full
    // stored pair. A byte overridden by a higher-priority write therefore
    // still passes its carry or borrow to the other byte.
    for (gi = 0; gi < PAIRS; gi++) begin : g_pair
        logic [2*WIDTH-1:0] w_pair_cur;

        assign w_pair_cur     = {w_regs[2*gi], w_regs[2*gi+1]};
        assign w_step_val[gi] = (i_IncDec == 2'b01) ? (w_pair_cur + ONE)
                                                    : (w_pair_cur - ONE);
        assign w_step_hit[gi] = (i_IncDec[0] ^ i_IncDec[1])
                              && (i_IncDecPair == PW'(gi));
        assign w_pair_hit[gi] = i_WrPair && (i_WrPairAddr == PW'(gi));
    end

    // One register per byte, each with its own priority chain.
    for (gi = 0; gi < N; gi++) begin : g_byte
        localparam int               P    = gi / 2;
        localparam int               LSB  = ((gi % 2) == 0) ? WIDTH : 0;
        localparam logic [WIDTH-1:0] MASK = (gi == FLAG_REG) ? FLAG_MASK : '1;
        localparam logic [WIDTH-1:0] RST  = INITIAL & MASK;

        logic             r_byte;
        logic [WIDTH-1:0] r_value;
        logic             w_byte_hit;

        assign w_byte_hit = i_WrByte && (i_WrAddr == AW'(gi));

        always_ff @(posedge i_Clk or negedge i_Reset_n) begin
            if (!i_Reset_n) begin
                r_value <= RST;
            end else if (i_Enable) begin
                if (w_byte_hit)
                    r_value <= i_WrData & MASK;
                else if (w_pair_hit[P])
                    r_value <= i_WrPairData[LSB +: WIDTH] & MASK;
                else if (w_step_hit[P])
                    r_value <= w_step_val[P][LSB +: WIDTH] & MASK;
            end
        end

        // r_byte is not used; it is tied off so that no flop is inferred.
        assign r_byte     = 1'b0;
        assign w_regs[gi] = r_value;
    end

    for (gi = 0; gi < (1 << AW); gi++) begin : g_rd_byte
        if (gi < N) begin : g_used
            assign w_rd_bytes[gi] = w_regs[gi];
        end else begin : g_pad
            assign w_rd_bytes[gi] = '0;
        end
    end

    for (gi = 0; gi < (1 << PW); gi++) begin : g_rd_pair
        if (gi < PAIRS) begin : g_used
            assign w_rd_pairs[gi] = {w_regs[2*gi], w_regs[2*gi+1]};
        end else begin : g_pad
            assign w_rd_pairs[gi] = '0;
        end
    end

    assign o_RdDataA    = w_rd_bytes[i_RdAddrA];
    assign o_RdDataB    = w_rd_bytes[i_RdAddrB];
    assign o_RdPairData = w_rd_pairs[i_RdPair];

endmodule

// File: tb/tb_register_bank.sv
// ---------------------------------------------------------------------------
// tb_register_bank
//   Directed vectors for register_bank with the default parameters.
//   A second instance uses PAIRS=3, so it has out-of-range byte and pair
//   addresses. It also has FLAG_REG outside the bank, so no byte is masked.
// ---------------------------------------------------------------------------
module tb_register_bank;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [2:0]  ra, rb;
    logic [1:0]  rp;
    logic        wb;
    logic [2:0]  wa;
    logic [7:0]  wd;
    logic        wp;
    logic [1:0]  wpa;
    logic [15:0] wpd;
    logic [1:0]  id;
    logic [1:0]  idp;

    logic [7:0]  a1, b1, a2, b2;
    logic [15:0] p1, p2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    register_bank dut (
        .i_Clk(clk), .i_Reset_n(rst_n), .i_Enable(en),
        .i_RdAddrA(ra), .i_RdAddrB(rb), .o_RdDataA(a1), .o_RdDataB(b1),
        .i_RdPair(rp), .o_RdPairData(p1),
        .i_WrByte(wb), .i_WrAddr(wa), .i_WrData(wd),
        .i_WrPair(wp), .i_WrPairAddr(wpa), .i_WrPairData(wpd),
        .i_IncDec(id), .i_IncDecPair(idp)
    );

    register_bank #(.PAIRS(3)) dut_small (
        .i_Clk(clk), .i_Reset_n(rst_n), .i_Enable(en),
        .i_RdAddrA(ra), .i_RdAddrB(rb), .o_RdDataA(a2), .o_RdDataB(b2),
        .i_RdPair(rp), .o_RdPairData(p2),
        .i_WrByte(wb), .i_WrAddr(wa), .i_WrData(wd),
        .i_WrPair(wp), .i_WrPairAddr(wpa), .i_WrPairData(wpd),
        .i_IncDec(id), .i_IncDecPair(idp)
    );

    typedef struct {
        logic        en;
        logic        wb;
        logic [2:0]  wa;
        logic [7:0]  wd;
        logic        wp;
        logic [1:0]  wpa;
        logic [15:0] wpd;
        logic [1:0]  id;
        logic [1:0]  idp;
        logic [2:0]  ra;
        logic [7:0]  ea;
        logic [1:0]  rp;
        logic [15:0] ep;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic idle();
        wb = 0; wa = 0; wd = 0; wp = 0; wpa = 0; wpd = 0; id = 0; idp = 0;
    endtask

    // Advance one rising edge and settle just past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        //            en wb wa    wd     wp wpa   wpd       id     idp   ra    ea     rp    ep
        vecs[0]  = '{1, 0, 3'd0, 8'h00, 1, 2'd3, 16'h12FF, 2'b00, 2'd0, 3'd6, 8'h12, 2'd3, 16'h12F0};
        vecs[1]  = '{1, 1, 3'd7, 8'hFF, 0, 2'd0, 16'h0000, 2'b00, 2'd0, 3'd7, 8'hF0, 2'd3, 16'h12F0};
        vecs[2]  = '{1, 0, 3'd0, 8'h00, 1, 2'd2, 16'hFFFF, 2'b00, 2'd0, 3'd4, 8'hFF, 2'd2, 16'hFFFF};
        vecs[3]  = '{1, 0, 3'd0, 8'h00, 0, 2'd0, 16'h0000, 2'b01, 2'd2, 3'd5, 8'h00, 2'd2, 16'h0000};
        vecs[4]  = '{1, 0, 3'd0, 8'h00, 0, 2'd0, 16'h0000, 2'b10, 2'd2, 3'd4, 8'hFF, 2'd2, 16'hFFFF};
        vecs[5]  = '{1, 0, 3'd0, 8'h00, 0, 2'd0, 16'h0000, 2'b11, 2'd2, 3'd5, 8'hFF, 2'd2, 16'hFFFF};
        vecs[6]  = '{1, 0, 3'd0, 8'h00, 1, 2'd0, 16'h00FF, 2'b00, 2'd0, 3'd1, 8'hFF, 2'd0, 16'h00FF};
        vecs[7]  = '{1, 1, 3'd1, 8'h55, 0, 2'd0, 16'h0000, 2'b01, 2'd0, 3'd0, 8'h01, 2'd0, 16'h0155};
        vecs[8]  = '{1, 0, 3'd0, 8'h00, 0, 2'd0, 16'h0000, 2'b01, 2'd3, 3'd7, 8'hF0, 2'd3, 16'h12F0};
        vecs[9]  = '{1, 0, 3'd0, 8'h00, 0, 2'd0, 16'h0000, 2'b10, 2'd3, 3'd7, 8'hE0, 2'd3, 16'h12E0};
        vecs[10] = '{1, 1, 3'd2, 8'hAA, 1, 2'd1, 16'h1234, 2'b01, 2'd1, 3'd2, 8'hAA, 2'd1, 16'hAA34};
        vecs[11] = '{1, 1, 3'd0, 8'h77, 1, 2'd2, 16'hABCD, 2'b01, 2'd1, 3'd0, 8'h77, 2'd1, 16'hAA35};
        vecs[12] = '{0, 1, 3'd4, 8'h00, 1, 2'd2, 16'h0000, 2'b10, 2'd2, 3'd4, 8'hAB, 2'd2, 16'hABCD};
        vecs[13] = '{1, 0, 3'd0, 8'h00, 0, 2'd0, 16'h0000, 2'b10, 2'd0, 3'd1, 8'h54, 2'd0, 16'h7754};
        vecs[14] = '{1, 0, 3'd0, 8'h00, 1, 2'd1, 16'h0100, 2'b00, 2'd0, 3'd3, 8'h00, 2'd1, 16'h0100};
        vecs[15] = '{1, 1, 3'd3, 8'h99, 0, 2'd0, 16'h0000, 2'b10, 2'd1, 3'd2, 8'h00, 2'd1, 16'h0099};

        // Reset is held across an edge with strobes active; nothing may load.
        rst_n = 0; en = 1; ra = 0; rb = 0; rp = 0;
        idle();
        wb = 1; wa = 3'd2; wd = 8'h3C;
        tick();
        idle();
        rst_n = 1;
        for (int i = 0; i < 8; i++) begin
            ra = 3'(i);
            #1;
            check($sformatf("reset_byte%0d", i), {8'h00, a1}, 16'h0000);
        end
        for (int i = 0; i < 4; i++) begin
            rp = 2'(i);
            #1;
            check($sformatf("reset_pair%0d", i), p1, 16'h0000);
        end
        $display("reset: all bytes and pairs read");

        // Table-driven vectors.
        for (int i = 0; i < 16; i++) begin
            en = vecs[i].en; wb = vecs[i].wb; wa = vecs[i].wa; wd = vecs[i].wd;
            wp = vecs[i].wp; wpa = vecs[i].wpa; wpd = vecs[i].wpd;
            id = vecs[i].id; idp = vecs[i].idp;
            tick();
            idle();
            en = 1;
            ra = vecs[i].ra; rp = vecs[i].rp;
            #1;
            $display("vec %0d: reg%0d=%h pair%0d=%h", i, ra, a1, rp, p1);
            check($sformatf("vec%0d_byte", i), {8'h00, a1}, {8'h00, vecs[i].ea});
            check($sformatf("vec%0d_pair", i), p1, vecs[i].ep);
        end
        // The bank now holds: 77 54 00 99 AB CD 12 E0.

        // All strobes are active while enable is low for three edges.
        en = 0; wb = 1; wa = 3'd0; wd = 8'hEE;
        wp = 1; wpa = 2'd1; wpd = 16'h1111; id = 2'b01; idp = 2'd2;
        ra = 3'd0; rp = 2'd1;
        for (int c = 0; c < 3; c++) begin
            tick();
            $display("hold cycle %0d: reg0=%h pair1=%h", c, a1, p1);
            check($sformatf("hold%0d_reg0", c), {8'h00, a1}, 16'h0077);
            check($sformatf("hold%0d_pair1", c), p1, 16'h0099);
        end
        en = 1;
        tick();
        idle();
        rp = 2'd2;
        #1;
        $display("re-enable: reg0=%h pair2=%h", a1, p2);
        check("reen_reg0", {8'h00, a1}, 16'h00EE);
        check("reen_pair2", p1, 16'hABCE);
        rp = 2'd1;
        #1;
        check("reen_pair1", p1, 16'h1111);

        // Reset asserted between edges must clear the bank at once.
        tick();
        #2;
        rst_n = 0;
        #1;
        for (int i = 0; i < 8; i++) begin
            ra = 3'(i); rb = 3'(7 - i);
            #0.1;
            check($sformatf("midreset_byte%0d", i), {a1, b1}, 16'h0000);
        end
        rp = 2'd1;
        #0.1;
        check("midreset_pair1", p1, 16'h0000);
        $display("mid-cycle reset: bank cleared before next edge");

        // A write is first taken on the edge after reset deasserts.
        wb = 1; wa = 3'd3; wd = 8'h5A; ra = 3'd3;
        tick();
        check("reset_blocks_write", {8'h00, a1}, 16'h0000);
        rst_n = 1;
        tick();
        idle();
        #1;
        $display("post-reset write: reg3=%h", a1);
        check("first_write_after_reset", {8'h00, a1}, 16'h005A);

        // Small instance: out-of-range addresses, unmasked top byte.
        rst_n = 0;
        #1;
        rst_n = 1;
        wb = 1; wa = 3'd6; wd = 8'h11; wp = 1; wpa = 2'd3; wpd = 16'h2222;
        id = 2'b01; idp = 2'd3;
        tick();
        idle();
        ra = 3'd6; rb = 3'd7; rp = 2'd3;
        #1;
        $display("small oob: reg6=%h reg7=%h pair3=%h", a2, b2, p2);
        check("small_oob_byte6", {8'h00, a2}, 16'h0000);
        check("small_oob_byte7", {8'h00, b2}, 16'h0000);
        check("small_oob_pair3", p2, 16'h0000);
        for (int i = 0; i < 3; i++) begin
            rp = 2'(i);
            #1;
            check($sformatf("small_noleak_pair%0d", i), p2, 16'h0000);
        end
        check("big_byte6_written", {8'h00, a1}, 16'h0011);
        wp = 1; wpa = 2'd2; wpd = 16'hABFF;
        tick();
        idle();
        ra = 3'd5; rp = 2'd2;
        #1;
        $display("small pair2 write: reg5=%h pair2=%h", a2, p2);
        check("small_reg5_unmasked", {8'h00, a2}, 16'h00FF);
        check("small_pair2", p2, 16'hABFF);
        id = 2'b01; idp = 2'd2;
        tick();
        idle();
        #1;
        $display("small pair2 inc: pair2=%h", p2);
        check("small_pair2_inc", p2, 16'hAC00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/register_bank.md
REGISTER_BANK -- requirements
Module: register_bank

Interface
REQ-001 SHALL have parameter WIDTH, default 8: bit width of each byte register.
REQ-002 SHALL have parameter PAIRS, default 4: number of register pairs; register count N = 2*PAIRS; PAIRS >= 1.
REQ-003 SHALL have parameter INITIAL, default 0: reset/power-up value of every register (masked per REQ-019).
REQ-004 SHALL have parameter FLAG_REG, default 7: index of the flag register; a value >= N disables masking.
REQ-005 SHALL have parameter FLAG_MASK, default 8'hF0: writable bits of FLAG_REG; 0 bits are always stored as 0.
REQ-006 SHALL derive localparam AW = max(1, clog2(N)) for byte addresses and PW = max(1, clog2(PAIRS)) for pair addresses.
REQ-007 i_Clk  input  1  system clock; all state updates on rising edge.
REQ-008 i_Reset_n  input  1  asynchronous, active-low reset.
REQ-009 i_Enable  input  1  tick gate; when 0, no register changes.
REQ-010 i_RdAddrA / i_RdAddrB  input  AW  byte read addresses.
REQ-011 o_RdDataA / o_RdDataB  output  WIDTH  combinational byte read data.
REQ-012 i_RdPair  input  PW  pair read address.
REQ-013 o_RdPairData  output  2*WIDTH  {reg[2p], reg[2p+1]}, even index = high byte.
REQ-014 i_WrByte, i_WrAddr (AW), i_WrData (WIDTH)  input  byte write strobe, address, data.
REQ-015 i_WrPair, i_WrPairAddr (PW), i_WrPairData (2*WIDTH)  input  pair write strobe, address, data.
REQ-016 i_IncDec (2), i_IncDecPair (PW)  input  pair step: 01 increment, 10 decrement, 00/11 no-op.

Function
REQ-017 Reads SHALL be combinational from stored state, no write bypass; a write appears on read ports the cycle after its clock edge.
REQ-018 Read addresses >= N (or pair >= PAIRS) SHALL return 0; writes/steps to such addresses SHALL be ignored.
REQ-019 Every value stored into FLAG_REG (byte write, pair write, inc/dec, reset) SHALL be ANDed with FLAG_MASK.
REQ-020 Byte write: on rising edge with i_Enable=1 and i_WrByte=1, reg[i_WrAddr] <= i_WrData.
REQ-021 Pair write: on rising edge with i_Enable=1 and i_WrPair=1, reg[2p] <= data[2W-1:W], reg[2p+1] <= data[W-1:0].
REQ-022 Inc/dec: on rising edge with i_Enable=1, pair value {hi,lo} SHALL become value +/- 1 modulo 2^(2*WIDTH), computed from stored (pre-mask) bytes.
REQ-023 Wrap-around: all-ones + 1 -> 0; 0 - 1 -> all-ones (then masked per REQ-019 if FLAG_REG in pair).
REQ-024 Per-byte precedence on simultaneous events SHALL be: byte write > pair write > inc/dec; lower-priority sources still update bytes they alone target.
REQ-025 Inc/dec carry/borrow SHALL be computed on the full pair even when one byte is overridden by a higher-priority write in the same cycle.
REQ-026 i_Enable=0 SHALL hold all registers regardless of strobes; read ports remain active.
REQ-027 Any number of independent bytes SHALL be updatable in one cycle (up to one byte write, one pair write, one step).

Reset
REQ-028 i_Reset_n=0 SHALL immediately (no clock) set every register to INITIAL, FLAG_REG to INITIAL & FLAG_MASK.
REQ-029 Reset SHALL override i_Enable and all strobes; first update occurs on first rising edge after i_Reset_n deasserts.
REQ-030 Power-up initial value SHALL equal the reset value.

Verification
REQ-031 Reset, defaults: after i_Reset_n pulse -> all o_RdData = 0, o_RdPairData = 16'h0000.
REQ-032 Pair write 16'h12FF to pair 3, then read -> o_RdPairData = 16'h12F0 (F masked), reg6 = 8'h12.
REQ-033 Pair 2 = 16'hFFFF, i_IncDec=01 -> 16'h0000; then 10 -> 16'hFFFF; i_IncDec=11 -> unchanged.
REQ-034 Pair 0 = 16'h00FF, inc + byte write reg1=8'h55 same cycle -> reg0=8'h01, reg1=8'h55.
REQ-035 i_Enable=0 with all strobes active for 3 cycles -> no register changes; re-enable -> updates on next edge.
REQ-036 Assert i_Reset_n=0 mid-cycle between edges after writes -> registers return to INITIAL before next edge.
